// File: rtl/gray_pkg.sv
// Shared mode encodings and Gray-code helpers for the pipelined Gray engine.
// Helpers operate on a GRAY_MAX_W-bit word; narrower users zero-extend and truncate.
package gray_pkg;

  localparam int unsigned GRAY_MAX_W = 64;

  localparam logic [1:0] MODO_B2G = 2'b00;
  localparam logic [1:0] MODO_G2B = 2'b01;
  localparam logic [1:0] MODO_INC = 2'b10;
  localparam logic [1:0] MODO_RSV = 2'b11;

  typedef logic [GRAY_MAX_W-1:0] gray_word_t;

  function automatic gray_word_t bin2gray(input gray_word_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic gray_word_t gray2bin(input gray_word_t g);
    gray_word_t b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = int'(GRAY_MAX_W) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/conversor_gray_param_pipe_if.sv
// Producer/consumer handshake bundle for the Gray engine.
interface conversor_gray_param_pipe_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] dato_in;
  logic [1:0]       modo;
  logic             valido_in;
  logic             listo_in;
  logic [WIDTH-1:0] dato_out;
  logic             error_modo;
  logic             valido_out;
  logic             listo_out;

  modport master (
    output dato_in, modo, valido_in, listo_out,
    input  listo_in, dato_out, error_modo, valido_out
  );

  modport slave (
    input  dato_in, modo, valido_in, listo_out,
    output listo_in, dato_out, error_modo, valido_out
  );
endinterface

// File: rtl/gray_prefijo_bloque.sv
// CHUNK-bit suffix XOR: bit i is the XOR of gray_i[CHUNK-1:i]; no carry input.
module gray_prefijo_bloque #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] gray_i,
  output logic [CHUNK-1:0] pref_o
);
  always_comb begin
    pref_o[CHUNK-1] = gray_i[CHUNK-1];
    for (int i = int'(CHUNK) - 2; i >= 0; i--) begin
      pref_o[i] = pref_o[i+1] ^ gray_i[i];
    end
  end
endmodule

// File: rtl/conversor_gray_param_pipe.sv
// Two-stage Gray engine: S1 registers per-chunk suffix XORs, S2 resolves the
// inter-chunk carry, applies the mode and holds the result under backpressure.
module conversor_gray_param_pipe
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 4
) (
  input logic                        clk,
  input logic                        rst_n,
  conversor_gray_param_pipe_if.slave bus
);
  localparam int unsigned NCHUNK = WIDTH / CHUNK;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_dato_q, s1_dato_d;
  logic [WIDTH-1:0] s1_pref_q, s1_pref_d;
  logic [1:0]       s1_modo_q, s1_modo_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_dato_q, s2_dato_d;
  logic             s2_err_q, s2_err_d;

  logic             s1_adv, s2_adv;
  logic [WIDTH-1:0] pref_w, bin_w, bin_inc_w, res_w;
  logic             err_w;

  for (genvar j = 0; j < NCHUNK; j++) begin : g_bloque
    gray_prefijo_bloque #(
      .CHUNK (CHUNK)
    ) u_bloque (
      .gray_i (bus.dato_in[j*CHUNK +: CHUNK]),
      .pref_o (pref_w[j*CHUNK +: CHUNK])
    );
  end

  // Carry into a chunk is the parity of all Gray bits above it; bit 0 of each
  // chunk's suffix XOR is exactly that chunk's parity.
  always_comb begin
    logic carry;
    carry = 1'b0;
    bin_w = '0;
    for (int j = int'(NCHUNK) - 1; j >= 0; j--) begin
      for (int i = 0; i < int'(CHUNK); i++) begin
        bin_w[j*CHUNK+i] = s1_pref_q[j*CHUNK+i] ^ carry;
      end
      carry = carry ^ s1_pref_q[j*CHUNK];
    end
  end

  assign bin_inc_w = bin_w + WIDTH'(1);

  always_comb begin
    res_w = s1_dato_q;
    err_w = 1'b0;
    case (s1_modo_q)
      MODO_B2G: res_w = WIDTH'(bin2gray(gray_word_t'(s1_dato_q)));
      MODO_G2B: res_w = bin_w;
      MODO_INC: res_w = WIDTH'(bin2gray(gray_word_t'(bin_inc_w)));
      default:  err_w = 1'b1;
    endcase
  end

  always_comb begin
    s2_adv = !s2_valid_q || bus.listo_out;
    s1_adv = !s1_valid_q || s2_adv;

    s1_valid_d = s1_valid_q;
    s1_dato_d  = s1_dato_q;
    s1_pref_d  = s1_pref_q;
    s1_modo_d  = s1_modo_q;
    if (s1_adv) begin
      s1_valid_d = bus.valido_in;
      if (bus.valido_in) begin
        s1_dato_d = bus.dato_in;
        s1_pref_d = pref_w;
        s1_modo_d = bus.modo;
      end
    end

    s2_valid_d = s2_valid_q;
    s2_dato_d  = s2_dato_q;
    s2_err_d   = s2_err_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_dato_d = res_w;
        s2_err_d  = err_w;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_dato_q  <= '0;
      s1_pref_q  <= '0;
      s1_modo_q  <= MODO_B2G;
      s2_valid_q <= 1'b0;
      s2_dato_q  <= '0;
      s2_err_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_dato_q  <= s1_dato_d;
      s1_pref_q  <= s1_pref_d;
      s1_modo_q  <= s1_modo_d;
      s2_valid_q <= s2_valid_d;
      s2_dato_q  <= s2_dato_d;
      s2_err_q   <= s2_err_d;
    end
  end

  assign bus.listo_in   = s1_adv;
  assign bus.valido_out = s2_valid_q;
  assign bus.dato_out   = s2_dato_q;
  assign bus.error_modo = s2_err_q;
endmodule

// File: tb/tb_conversor_gray_param_pipe.sv
// Self-checking bench: 8-bit and 16-bit engines against a table-driven Gray model.
module tb_conversor_gray_param_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [15:0] inv_tbl [65536];

  conversor_gray_param_pipe_if #(.WIDTH(8))  bus8 ();
  conversor_gray_param_pipe_if #(.WIDTH(16)) bus16 ();

  conversor_gray_param_pipe #(.WIDTH(8), .CHUNK(4)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  conversor_gray_param_pipe #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got=timeout required=finish");
    $fatal(1);
  end

  // {error, data}; Gray->binary comes from an inverse table of b^(b>>1)
  function automatic logic [16:0] model(input int w, input logic [15:0] d,
                                        input logic [1:0] m);
    logic [15:0] mask;
    logic [15:0] b;
    mask = (w == 16) ? 16'hFFFF : 16'h00FF;
    case (m)
      2'd0: return {1'b0, (d ^ (d >> 1)) & mask};
      2'd1: return {1'b0, inv_tbl[d] & mask};
      2'd2: begin
        b = (inv_tbl[d] + 16'd1) & mask;
        return {1'b0, b ^ (b >> 1)};
      end
      default: return {1'b1, d & mask};
    endcase
  endfunction

  task automatic xfer8(input logic [7:0] d, input logic [1:0] m,
                       output logic [7:0] dout, output logic err, output bit ok);
    int n;
    ok = 1'b0; dout = '0; err = 1'b0;
    @(negedge clk);
    bus8.dato_in = d; bus8.modo = m; bus8.valido_in = 1'b1; bus8.listo_out = 1'b1;
    #1;
    n = 0;
    while (!bus8.listo_in && n < 10) begin @(negedge clk); #1; n++; end
    @(negedge clk);
    bus8.valido_in = 1'b0;
    for (int k = 0; k < 10 && !ok; k++) begin
      #1;
      if (bus8.valido_out) begin
        ok = 1'b1; dout = bus8.dato_out; err = bus8.error_modo;
      end else @(negedge clk);
    end
  endtask

  task automatic xfer16(input logic [15:0] d, input logic [1:0] m,
                        output logic [15:0] dout, output logic err, output bit ok);
    int n;
    ok = 1'b0; dout = '0; err = 1'b0;
    @(negedge clk);
    bus16.dato_in = d; bus16.modo = m; bus16.valido_in = 1'b1; bus16.listo_out = 1'b1;
    #1;
    n = 0;
    while (!bus16.listo_in && n < 10) begin @(negedge clk); #1; n++; end
    @(negedge clk);
    bus16.valido_in = 1'b0;
    for (int k = 0; k < 10 && !ok; k++) begin
      #1;
      if (bus16.valido_out) begin
        ok = 1'b1; dout = bus16.dato_out; err = bus16.error_modo;
      end else @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #23;
    n_checks++;
    if (bus8.valido_out !== 1'b0 || bus8.dato_out !== 8'h00 || bus8.error_modo !== 1'b0) begin
      n_fail++;
      $display("FAIL reset8_outputs: got v=%b d=%h e=%b, required v=0 d=00 e=0",
               bus8.valido_out, bus8.dato_out, bus8.error_modo);
    end
    n_checks++;
    if (bus8.listo_in !== 1'b1 || bus16.listo_in !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_listo_in: got %b/%b, required 1/1", bus8.listo_in, bus16.listo_in);
    end
    n_checks++;
    if (bus16.valido_out !== 1'b0 || bus16.dato_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset16_outputs: got v=%b d=%h, required v=0 d=0000",
               bus16.valido_out, bus16.dato_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_b2g();
    @(negedge clk);
    bus8.dato_in = 8'hB5; bus8.modo = 2'b00; bus8.valido_in = 1'b1; bus8.listo_out = 1'b1;
    #1;
    n_checks++;
    if (bus8.listo_in !== 1'b1) begin
      n_fail++; $display("FAIL b2g_accept: listo_in got %b required 1", bus8.listo_in);
    end
    @(negedge clk);
    bus8.valido_in = 1'b0;
    #1;
    n_checks++;
    if (bus8.valido_out !== 1'b0) begin
      n_fail++; $display("FAIL b2g_latency_early: valido_out got %b required 0", bus8.valido_out);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (bus8.valido_out !== 1'b1 || bus8.dato_out !== 8'hEF || bus8.error_modo !== 1'b0) begin
      n_fail++;
      $display("FAIL b2g_B5: got v=%b d=%h e=%b, required v=1 d=ef e=0",
               bus8.valido_out, bus8.dato_out, bus8.error_modo);
    end
    @(negedge clk);
  endtask

  // Streams beats through the 8-bit engine, checking order, values and stall stability
  task automatic test_stream(input string name, input int nbeats, input int mode_sel,
                             input bit sweep, input int stall_pct, input int gap_pct);
    logic [16:0] exp_q[$];
    logic [16:0] e;
    int sent, got, cyc;
    bit have, prev_hold, prev_e;
    logic [7:0] d, prev_d;
    logic [1:0] m;
    sent = 0; got = 0; cyc = 0; have = 1'b0; prev_hold = 1'b0; prev_e = 1'b0;
    d = '0; prev_d = '0; m = '0;
    while (got < nbeats && cyc < nbeats * 20 + 50) begin
      @(negedge clk);
      cyc++;
      if (!have && sent < nbeats && int'($urandom_range(99)) >= gap_pct) begin
        d = sweep ? 8'(sent) : 8'($urandom);
        m = (mode_sel < 0) ? 2'($urandom) : 2'(mode_sel);
        have = 1'b1;
      end
      bus8.valido_in = have; bus8.dato_in = d; bus8.modo = m;
      bus8.listo_out = (int'($urandom_range(99)) >= stall_pct);
      #1;
      if (prev_hold) begin
        n_checks++;
        if (bus8.valido_out !== 1'b1 || bus8.dato_out !== prev_d || bus8.error_modo !== prev_e)
        begin
          n_fail++;
          $display("FAIL %s_hold: got v=%b d=%h e=%b, required v=1 d=%h e=%b", name,
                   bus8.valido_out, bus8.dato_out, bus8.error_modo, prev_d, prev_e);
        end
      end
      if (bus8.valido_out && bus8.listo_out) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s_spurious: got d=%h with no beat outstanding", name, bus8.dato_out);
        end else begin
          e = exp_q.pop_front();
          if (bus8.dato_out !== e[7:0] || bus8.error_modo !== e[16]) begin
            n_fail++;
            $display("FAIL %s_beat%0d: got d=%h e=%b, required d=%h e=%b", name, got,
                     bus8.dato_out, bus8.error_modo, e[7:0], e[16]);
          end
        end
        got++;
      end
      prev_hold = bus8.valido_out && !bus8.listo_out;
      prev_d = bus8.dato_out;
      prev_e = bus8.error_modo;
      if (have && bus8.listo_in) begin
        exp_q.push_back(model(8, {8'h00, d}, m));
        sent++;
        have = 1'b0;
      end
    end
    @(negedge clk);
    bus8.valido_in = 1'b0; bus8.listo_out = 1'b1;
    n_checks++;
    if (got != nbeats) begin
      n_fail++;
      $display("FAIL %s_count: got %0d beats, required %0d", name, got, nbeats);
    end
    @(negedge clk);
  endtask

  task automatic test_increment();
    logic [7:0] dout; logic err; bit ok;
    xfer8(8'hEF, 2'b10, dout, err, ok);
    n_checks++;
    if (!ok || dout !== 8'hED || err !== 1'b0) begin
      n_fail++; $display("FAIL inc_EF: got ok=%b d=%h e=%b, required d=ed e=0", ok, dout, err);
    end
    xfer8(8'h80, 2'b10, dout, err, ok);
    n_checks++;
    if (!ok || dout !== 8'h00 || err !== 1'b0) begin
      n_fail++; $display("FAIL inc_wrap80: got ok=%b d=%h e=%b, required d=00 e=0", ok, dout, err);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_seq [3];
    exp_seq[0] = 8'h01; exp_seq[1] = 8'h03; exp_seq[2] = 8'h02;
    @(negedge clk);
    bus8.listo_out = 1'b0; bus8.valido_in = 1'b1; bus8.modo = 2'b00; bus8.dato_in = 8'h01;
    #1;
    n_checks++;
    if (bus8.listo_in !== 1'b1) begin
      n_fail++; $display("FAIL bp_accept1: listo_in got %b required 1", bus8.listo_in);
    end
    @(negedge clk);
    bus8.dato_in = 8'h02;
    #1;
    n_checks++;
    if (bus8.listo_in !== 1'b1) begin
      n_fail++; $display("FAIL bp_accept2: listo_in got %b required 1", bus8.listo_in);
    end
    @(negedge clk);
    bus8.dato_in = 8'h03;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if (bus8.listo_in !== 1'b0 || bus8.valido_out !== 1'b1 || bus8.dato_out !== 8'h01) begin
        n_fail++;
        $display("FAIL bp_stall%0d: got li=%b v=%b d=%h, required li=0 v=1 d=01", k,
                 bus8.listo_in, bus8.valido_out, bus8.dato_out);
      end
      @(negedge clk);
    end
    bus8.listo_out = 1'b1;
    #1;
    n_checks++;
    if (bus8.listo_in !== 1'b1) begin
      n_fail++; $display("FAIL bp_release: listo_in got %b required 1", bus8.listo_in);
    end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin @(negedge clk); bus8.valido_in = 1'b0; #1; end
      n_checks++;
      if (bus8.valido_out !== 1'b1 || bus8.dato_out !== exp_seq[k]) begin
        n_fail++;
        $display("FAIL bp_drain%0d: got v=%b d=%h, required v=1 d=%h", k,
                 bus8.valido_out, bus8.dato_out, exp_seq[k]);
      end
    end
    @(negedge clk);
    bus8.valido_in = 1'b0;
    #1;
    n_checks++;
    if (bus8.valido_out !== 1'b0) begin
      n_fail++; $display("FAIL bp_empty: valido_out got %b required 0", bus8.valido_out);
    end
  endtask

  task automatic test_reserved();
    logic [7:0] dout; logic err; bit ok;
    xfer8(8'h5A, 2'b11, dout, err, ok);
    n_checks++;
    if (!ok || dout !== 8'h5A || err !== 1'b1) begin
      n_fail++; $display("FAIL rsv_5A: got ok=%b d=%h e=%b, required d=5a e=1", ok, dout, err);
    end
    xfer8(8'h3C, 2'b00, dout, err, ok);
    n_checks++;
    if (!ok || dout !== 8'h22 || err !== 1'b0) begin
      n_fail++; $display("FAIL rsv_clear: got ok=%b d=%h e=%b, required d=22 e=0", ok, dout, err);
    end
  endtask

  task automatic test_reset_midstream();
    logic [7:0] d8; logic [15:0] d16; logic err; bit ok;
    logic [16:0] e;
    @(negedge clk);
    bus8.listo_out = 1'b0; bus16.listo_out = 1'b0;
    bus8.valido_in = 1'b1; bus8.dato_in = 8'hA7; bus8.modo = 2'b00;
    bus16.valido_in = 1'b1; bus16.dato_in = 16'h1234; bus16.modo = 2'b01;
    @(negedge clk);
    bus8.dato_in = 8'h5C; bus16.dato_in = 16'hABCD;
    @(negedge clk);
    bus8.valido_in = 1'b0; bus16.valido_in = 1'b0;
    #1;
    n_checks++;
    if (bus8.valido_out !== 1'b1 || bus8.listo_in !== 1'b0 ||
        bus16.valido_out !== 1'b1 || bus16.listo_in !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_full: got v8=%b li8=%b v16=%b li16=%b, required 1 0 1 0",
               bus8.valido_out, bus8.listo_in, bus16.valido_out, bus16.listo_in);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus8.valido_out !== 1'b0 || bus8.dato_out !== 8'h00 || bus8.listo_in !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid8: got v=%b d=%h li=%b, required v=0 d=00 li=1",
               bus8.valido_out, bus8.dato_out, bus8.listo_in);
    end
    n_checks++;
    if (bus16.valido_out !== 1'b0 || bus16.dato_out !== 16'h0000 || bus16.listo_in !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid16: got v=%b d=%h li=%b, required v=0 d=0000 li=1",
               bus16.valido_out, bus16.dato_out, bus16.listo_in);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus8.listo_out = 1'b1; bus16.listo_out = 1'b1;
    xfer8(8'h3C, 2'b10, d8, err, ok);
    e = model(8, 16'h003C, 2'b10);
    n_checks++;
    if (!ok || d8 !== e[7:0] || err !== 1'b0) begin
      n_fail++; $display("FAIL rst_first8: got ok=%b d=%h, required d=%h", ok, d8, e[7:0]);
    end
    xfer16(16'hF00D, 2'b10, d16, err, ok);
    e = model(16, 16'hF00D, 2'b10);
    n_checks++;
    if (!ok || d16 !== e[15:0] || err !== 1'b0) begin
      n_fail++; $display("FAIL rst_first16: got ok=%b d=%h, required d=%h", ok, d16, e[15:0]);
    end
  endtask

  task automatic test_width16();
    logic [15:0] d16; logic err; bit ok;
    logic [16:0] e;
    logic [15:0] din;
    logic [1:0]  m;
    xfer16(16'h8000, 2'b10, d16, err, ok);
    n_checks++;
    if (!ok || d16 !== 16'h0000 || err !== 1'b0) begin
      n_fail++; $display("FAIL w16_wrap: got ok=%b d=%h e=%b, required d=0000 e=0", ok, d16, err);
    end
    for (int k = 0; k < 24; k++) begin
      din = 16'($urandom);
      m = 2'(k % 4);
      xfer16(din, m, d16, err, ok);
      e = model(16, din, m);
      n_checks++;
      if (!ok || d16 !== e[15:0] || err !== e[16]) begin
        n_fail++;
        $display("FAIL w16_rand%0d: in=%h m=%0d got ok=%b d=%h e=%b, required d=%h e=%b",
                 k, din, m, ok, d16, err, e[15:0], e[16]);
      end
    end
  endtask

  initial begin
    bus8.dato_in = '0; bus8.modo = '0; bus8.valido_in = 1'b0; bus8.listo_out = 1'b1;
    bus16.dato_in = '0; bus16.modo = '0; bus16.valido_in = 1'b0; bus16.listo_out = 1'b1;
    for (int b = 0; b < 65536; b++) begin
      logic [15:0] bb;
      bb = 16'(b);
      inv_tbl[bb ^ (bb >> 1)] = bb;
    end
    test_reset();
    test_b2g();
    test_stream("g2b_sweep", 256, 1, 1'b1, 0, 0);
    test_increment();
    test_backpressure();
    test_reserved();
    test_stream("random", 300, -1, 1'b0, 30, 20);
    test_reset_midstream();
    test_width16();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conversor_gray_param_pipe.md
# conversor_gray_param_pipe

Parametrised, pipelined Gray-code engine, the next generation of the team's fixed 8-bit binary-to-Gray converters. It converts binary to Gray, Gray to binary, or advances a Gray code by one step, selected per beat. Each stage has a valid/ready handshake. It sits between pointer/counter producers and clock-domain-crossing or position-encoder logic, where a registered, back-pressurable result is required.

## Interface
- `WIDTH`, 8: data width in bits; must be a multiple of `CHUNK`, ≥ `CHUNK`.
- `CHUNK`, 4: bit width of the prefix-XOR blocks used by Gray-to-binary (nibble blocks with carry between blocks).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `dato_in`  in  WIDTH  operand (binary or Gray, per `modo`).
- `modo`  in  2  00 bin→gray, 01 gray→bin, 10 gray increment, 11 reserved.
- `valido_in`  in  1  beat offered.
- `listo_in`  out  1  engine can accept; beat transfers when `valido_in && listo_in` at a rising edge.
- `dato_out`  out  WIDTH  registered result.
- `error_modo`  out  1  registered; 1 when the beat used `modo`=11.
- `valido_out`  out  1  result held on `dato_out`.
- `listo_out`  in  1  consumer ready; result transfers when `valido_out && listo_out`.

## Operation
- Two register stages, S1 and S2. S2 is the output register.
- S1 captures `dato_in`, `modo` and per-chunk partial prefix-XOR results. For chunk j, bit i holds the XOR of the chunk bits from i up to the chunk MSB.
- S2 resolves the inter-chunk carry. The carry into chunk j is the parity of all Gray bits above chunk j. Each bit of chunk j is XORed with that carry. S2 then applies the mode:
  - 00: `dato_out = b ^ (b >> 1)`.
  - 01: `dato_out` = resolved binary.
  - 10: `dato_out = bin2gray(resolved_binary + 1)`, computed modulo 2^WIDTH. The all-ones binary (Gray `1000…0`) wraps to Gray 0.
  - 11: `dato_out = dato_in` unchanged and `error_modo = 1`. Every other mode drives `error_modo = 0`.
- Handshake and stalls:
  - S2 advances when it is empty or when `listo_out` is 1.
  - S1 advances when it is empty or when S2 advances.
  - `listo_in = !S1_valid || S2_advance`. This is combinational, with no path from `valido_in`.
- Backpressure: when S2 is full and `listo_out` is 0, `dato_out`, `error_modo` and `valido_out` hold stable. No beat is dropped or duplicated.
- Simultaneous events: when S1 and S2 are full and `listo_out` is 1, a new beat is accepted on the same edge (full throughput).
- Reset values:
  - `valido_out`=0, `dato_out`=0, `error_modo`=0.
  - S1 is emptied and its data cleared.
  - `listo_in` reads 1 while reset is asserted.
- Reset mid-operation: asserting `rst_n` low clears both stages immediately, without waiting for a clock edge. In-flight beats are discarded.

## Timing
- A beat accepted at rising edge N is presented on `dato_out`/`valido_out` after edge N+1 (two-register latency, one cycle of lookahead).
- Throughput is one beat per cycle when `listo_out` is held at 1.
- With `listo_out` held at 0 from empty, exactly two beats are accepted. `listo_in` then drops to 0 in the cycle after the second acceptance.
- Worst-case logic paths:
  - S1: within a chunk, `CHUNK`-deep XOR.
  - S2: chunk-carry XOR, then a `WIDTH`-bit incrementer, then a 1-level XOR.

## Structure
- Shared package `gray_pkg`:
  - mode localparams `MODO_B2G`, `MODO_G2B`, `MODO_INC`, `MODO_RSV`.
  - function `bin2gray`.
  - function `gray2bin` (reference model for the bench).
- One natural sub-module, `gray_prefijo_bloque`: a `CHUNK`-bit suffix XOR with no carry input, instantiated `WIDTH/CHUNK` times in S1.

## Test plan
- B2G, WIDTH=8: `dato_in`=8'hB5, `modo`=00 → `dato_out`=8'hEF, `error_modo`=0, `valido_out` high one edge after acceptance.
- G2B: 8'hEF, `modo`=01 → 8'hB5. Sweep all 256 values and check against `gray_pkg::gray2bin`.
- Increment:
  - 8'hEF, `modo`=10 → 8'hED.
  - Wrap: 8'h80, `modo`=10 → 8'h00.
- Backpressure: hold `listo_out`=0 and offer beats 8'h01, 8'h02, 8'h03 on consecutive cycles → only two accepted, `listo_in`=0. Output holds 8'h01 (B2G). Release `listo_out` → outputs 8'h01, 8'h03, 8'h02 (B2G of 01, 02, 03) in order, with no gaps once the third beat is accepted.
- Reserved mode: 8'h5A, `modo`=11 → `dato_out`=8'h5A, `error_modo`=1. The next beat in `modo`=00 clears `error_modo`.
- Reset mid-stream: pull `rst_n` low between edges while both stages are full → `valido_out`=0 and `dato_out`=0 immediately. After release, the first output is the first beat offered after reset. Repeat with WIDTH=16, CHUNK=4.
